// File: rtl/gpio_in_irq_pkg.sv
// Shared definitions for the gpio_in_irq peripheral: per-channel register offsets.
package gpio_in_irq_pkg;

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_RISE = 2'd1,
    REG_FALL = 2'd2,
    REG_PEND = 2'd3
  } regSel_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// One 8-bit input channel: multi-stage synchroniser, previous-value register and
// combinational rise/fall detection against that previous value.
module gpio_sync_edge #(
  parameter int sync_stages = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pins,
  output logic [7:0] sync,
  output logic [7:0] rise,
  output logic [7:0] fall
);

  logic [7:0] r_sync [sync_stages];
  logic [7:0] r_prev;

  // Shift the raw pins through the synchroniser and remember the last synchronised value
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < sync_stages; i++) begin
        r_sync[i] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_sync[0] <= pins;
      for (int i = 1; i < sync_stages; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[sync_stages-1];
    end
  end

  assign sync = r_sync[sync_stages-1];
  assign rise = sync & ~r_prev;
  assign fall = ~sync & r_prev;

endmodule

// File: rtl/gpio_in_irq.sv
// Multi-channel GPIO input block with edge capture, W1C pending flags and a
// single registered level interrupt, on the 8-bit peripheral bus.
module gpio_in_irq
  import gpio_in_irq_pkg::*;
#(
  parameter int channels    = 2,
  parameter int sync_stages = 2,
  parameter int size_addr   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8*channels-1:0] pins,
  input  logic                  read,
  input  logic                  write,
  input  logic [size_addr-1:0]  address,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  output logic                  ready_r,
  output logic                  ready_w,
  output logic                  irq
);

  logic [7:0] w_sync  [channels];
  logic [7:0] w_rise  [channels];
  logic [7:0] w_fall  [channels];
  logic [7:0] w_clear [channels];

  logic [7:0] r_riseEn [channels];
  logic [7:0] r_fallEn [channels];
  logic [7:0] r_pend   [channels];

  regSel_e     w_reg;
  logic [31:0] w_chanIdx;
  logic [7:0]  w_readData;
  logic        w_anyPend;

  assign w_reg     = regSel_e'(address[1:0]);
  assign w_chanIdx = 32'(address[size_addr-1:2]);

  genvar g;
  generate
    for (g = 0; g < channels; g++) begin : g_chan
      gpio_sync_edge #(
        .sync_stages(sync_stages)
      ) u_syncEdge (
        .clk  (clk),
        .reset(reset),
        .pins (pins[8*g +: 8]),
        .sync (w_sync[g]),
        .rise (w_rise[g]),
        .fall (w_fall[g])
      );
    end
  endgenerate

  // Read mux; an index past the last channel matches nothing and reads as zero
  always_comb begin
    w_readData = '0;
    for (int c = 0; c < channels; c++) begin
      if (w_chanIdx == 32'(c)) begin
        case (w_reg)
          REG_DATA: w_readData = w_sync[c];
          REG_RISE: w_readData = r_riseEn[c];
          REG_FALL: w_readData = r_fallEn[c];
          REG_PEND: w_readData = r_pend[c];
        endcase
      end
    end
  end

  // Per-channel W1C mask and the OR of every pending flag for the interrupt
  always_comb begin
    w_anyPend = 1'b0;
    for (int c = 0; c < channels; c++) begin
      w_clear[c] = '0;
      if (write && (w_chanIdx == 32'(c)) && (w_reg == REG_PEND)) begin
        w_clear[c] = data_in;
      end
      w_anyPend = w_anyPend | (|r_pend[c]);
    end
  end

  // Enable-mask writes and pending capture; a new edge wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < channels; c++) begin
        r_riseEn[c] <= '0;
        r_fallEn[c] <= '0;
        r_pend[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < channels; c++) begin
        if (write && (w_chanIdx == 32'(c)) && (w_reg == REG_RISE)) begin
          r_riseEn[c] <= data_in;
        end
        if (write && (w_chanIdx == 32'(c)) && (w_reg == REG_FALL)) begin
          r_fallEn[c] <= data_in;
        end
        r_pend[c] <= (r_pend[c] & ~w_clear[c])
                   | (w_rise[c] & r_riseEn[c])
                   | (w_fall[c] & r_fallEn[c]);
      end
    end
  end

  // Registered bus responses and interrupt; reset discards any in-flight acknowledge
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
      ready_r  <= 1'b0;
      ready_w  <= 1'b0;
      irq      <= 1'b0;
    end else begin
      ready_r <= read;
      ready_w <= write;
      irq     <= w_anyPend;
      if (read) begin
        data_out <= w_readData;
      end
    end
  end

endmodule

// File: tb/tb_gpio_in_irq.sv
// Self-checking bench for gpio_in_irq: register table sweep plus timed
// sequences for synchroniser latency, irq timing, W1C collisions and reset.
module tb_gpio_in_irq;
  import gpio_in_irq_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] pins;
  logic        read;
  logic        write;
  logic [3:0]  address;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        ready_r;
  logic        ready_w;
  logic        irq;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] expQ[$];
  string      nameQ[$];
  int         nVec  = 0;
  int         nMiss = 0;

  gpio_in_irq #(
    .channels   (2),
    .sync_stages(2),
    .size_addr  (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pins    (pins),
    .read    (read),
    .write   (write),
    .address (address),
    .data_in (data_in),
    .data_out(data_out),
    .ready_r (ready_r),
    .ready_w (ready_w),
    .irq     (irq)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a sequence never returns
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] ad(input logic [1:0] ch, input regSel_e r);
    return {ch, r};
  endfunction

  function automatic vec_t mk(input logic rd, input logic wr, input logic [3:0] a,
                              input logic [7:0] wd, input logic [7:0] ex, input string nm);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.exp = ex; v.name = nm;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  // Drives one bus cycle from a negedge, then checks the acknowledges and pops
  // the scoreboard at the following negedge
  task automatic applyStimulus(input logic rd, input logic wr, input logic [3:0] addr,
                               input logic [7:0] wdata, input logic [7:0] exp, input string name);
    read = rd; write = wr; address = addr; data_in = wdata;
    if (rd) begin
      expQ.push_back(exp);
      nameQ.push_back(name);
    end
    @(posedge clk);
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    checkOutput({name, "/ready_r"}, {7'd0, ready_r}, {7'd0, rd});
    checkOutput({name, "/ready_w"}, {7'd0, ready_w}, {7'd0, wr});
    if (expQ.size() > 0) begin
      if (ready_r) begin
        checkOutput(nameQ.pop_front(), data_out, expQ.pop_front());
      end else begin
        void'(expQ.pop_front());
        void'(nameQ.pop_front());
      end
    end
  endtask

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; data_in = '0; pins = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_irq",      {7'd0, irq},     8'h00);
    checkOutput("rst_data_out", data_out,        8'h00);
    checkOutput("rst_ready_r",  {7'd0, ready_r}, 8'h00);

    vecs.push_back(mk(1, 0, ad(0, REG_DATA), 8'h00, 8'h00, "rst_ch0_data"));
    vecs.push_back(mk(1, 0, ad(0, REG_RISE), 8'h00, 8'h00, "rst_ch0_rise"));
    vecs.push_back(mk(1, 0, ad(0, REG_FALL), 8'h00, 8'h00, "rst_ch0_fall"));
    vecs.push_back(mk(1, 0, ad(0, REG_PEND), 8'h00, 8'h00, "rst_ch0_pend"));
    vecs.push_back(mk(1, 0, ad(1, REG_DATA), 8'h00, 8'h00, "rst_ch1_data"));
    vecs.push_back(mk(1, 0, ad(1, REG_RISE), 8'h00, 8'h00, "rst_ch1_rise"));
    vecs.push_back(mk(1, 0, ad(1, REG_FALL), 8'h00, 8'h00, "rst_ch1_fall"));
    vecs.push_back(mk(1, 0, ad(1, REG_PEND), 8'h00, 8'h00, "rst_ch1_pend"));
    vecs.push_back(mk(0, 1, ad(0, REG_RISE), 8'h5A, 8'h00, "wr_ch0_rise"));
    vecs.push_back(mk(1, 0, ad(0, REG_RISE), 8'h00, 8'h5A, "rd_ch0_rise"));
    vecs.push_back(mk(0, 1, ad(1, REG_FALL), 8'hC3, 8'h00, "wr_ch1_fall"));
    vecs.push_back(mk(1, 0, ad(1, REG_FALL), 8'h00, 8'hC3, "rd_ch1_fall"));
    vecs.push_back(mk(1, 0, ad(0, REG_FALL), 8'h00, 8'h00, "rd_ch0_fall_untouched"));
    vecs.push_back(mk(0, 1, ad(0, REG_DATA), 8'hFF, 8'h00, "wr_ch0_data"));
    vecs.push_back(mk(1, 0, ad(0, REG_DATA), 8'h00, 8'h00, "rd_ch0_data_ro"));
    vecs.push_back(mk(0, 1, ad(0, REG_PEND), 8'hFF, 8'h00, "wr_ch0_pend_w1c"));
    vecs.push_back(mk(1, 0, ad(0, REG_PEND), 8'h00, 8'h00, "rd_ch0_pend_w1c"));
    vecs.push_back(mk(1, 0, ad(2, REG_RISE), 8'h00, 8'h00, "rd_ch2_oor"));
    vecs.push_back(mk(0, 1, ad(3, REG_RISE), 8'hFF, 8'h00, "wr_ch3_oor"));
    vecs.push_back(mk(1, 0, ad(1, REG_RISE), 8'h00, 8'h00, "rd_ch1_rise_no_alias"));
    vecs.push_back(mk(0, 1, ad(0, REG_RISE), 8'h00, 8'h00, "clr_ch0_rise"));
    vecs.push_back(mk(0, 1, ad(1, REG_FALL), 8'h00, 8'h00, "clr_ch1_fall"));
    vecs.push_back(mk(1, 0, ad(0, REG_RISE), 8'h00, 8'h00, "rd_ch0_rise_clr"));
    vecs.push_back(mk(1, 0, ad(1, REG_FALL), 8'h00, 8'h00, "rd_ch1_fall_clr"));
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].name);
    end

    // Synchroniser latency: the change shows up in the third back-to-back read
    pins[7:0] = 8'hA5;
    applyStimulus(1, 0, ad(0, REG_DATA), 8'h00, 8'h00, "data_lat1");
    applyStimulus(1, 0, ad(0, REG_DATA), 8'h00, 8'h00, "data_lat2");
    applyStimulus(1, 0, ad(0, REG_DATA), 8'h00, 8'hA5, "data_lat3");
    applyStimulus(1, 0, ad(0, REG_PEND), 8'h00, 8'h00, "pend_ch0_disabled");
    checkOutput("irq_disabled", {7'd0, irq}, 8'h00);

    // Rising capture on channel 1 and irq one cycle behind pending
    applyStimulus(0, 1, ad(1, REG_RISE), 8'h0F, 8'h00, "wr_ch1_rise");
    pins[15:8] = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("irq_before", {7'd0, irq}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    checkOutput("irq_after", {7'd0, irq}, 8'h01);
    applyStimulus(1, 0, ad(1, REG_PEND), 8'h00, 8'h0F, "pend_ch1_rise");
    @(posedge clk);
    @(negedge clk);
    checkOutput("data_out_hold", data_out, 8'h0F);
    checkOutput("ready_r_one_cycle", {7'd0, ready_r}, 8'h00);

    // Partial then full W1C on channel 1
    applyStimulus(0, 1, ad(1, REG_PEND), 8'h03, 8'h00, "w1c_03");
    applyStimulus(1, 0, ad(1, REG_PEND), 8'h00, 8'h0C, "pend_after_03");
    checkOutput("irq_partial", {7'd0, irq}, 8'h01);
    applyStimulus(0, 1, ad(1, REG_PEND), 8'h0C, 8'h00, "w1c_0c");
    checkOutput("irq_lag", {7'd0, irq}, 8'h01);
    applyStimulus(1, 0, ad(1, REG_PEND), 8'h00, 8'h00, "pend_after_0c");
    checkOutput("irq_cleared", {7'd0, irq}, 8'h00);

    // Falling edge colliding with a W1C of the same bit
    applyStimulus(0, 1, ad(0, REG_FALL), 8'h01, 8'h00, "wr_ch0_fall");
    pins[7:0] = 8'hA4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    applyStimulus(0, 1, ad(0, REG_PEND), 8'h01, 8'h00, "w1c_collide");
    applyStimulus(1, 0, ad(0, REG_PEND), 8'h00, 8'h01, "set_wins");
    checkOutput("irq_set_wins", {7'd0, irq}, 8'h01);
    applyStimulus(0, 1, ad(0, REG_PEND), 8'h01, 8'h00, "w1c_ch0");
    applyStimulus(1, 0, ad(0, REG_PEND), 8'h00, 8'h00, "pend_ch0_cleared");

    // Same-cycle read and write, out-of-range channel
    applyStimulus(1, 1, ad(0, REG_FALL), 8'h77, 8'h01, "rdwr_pre_value");
    applyStimulus(1, 0, ad(0, REG_FALL), 8'h00, 8'h77, "rdwr_post_value");
    applyStimulus(1, 0, ad(3, REG_PEND), 8'h00, 8'h00, "oor_read");
    applyStimulus(0, 1, ad(3, REG_FALL), 8'hFF, 8'h00, "oor_write");
    applyStimulus(1, 0, ad(1, REG_FALL), 8'h00, 8'h00, "oor_no_effect");

    // Reset landing on an outstanding read
    read = 1'b1; address = ad(0, REG_FALL); reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    read = 1'b0; reset = 1'b0;
    checkOutput("rst_mid_ready_r",  {7'd0, ready_r}, 8'h00);
    checkOutput("rst_mid_data_out", data_out,        8'h00);

    // Pins held high across reset make rising edges that stay uncaptured
    repeat (4) @(posedge clk);
    @(negedge clk);
    applyStimulus(1, 0, ad(1, REG_PEND), 8'h00, 8'h00, "post_rst_pend_ch1");
    applyStimulus(1, 0, ad(0, REG_FALL), 8'h00, 8'h00, "post_rst_fall_ch0");
    applyStimulus(1, 0, ad(1, REG_DATA), 8'h00, 8'hFF, "post_rst_data_ch1");
    checkOutput("post_rst_irq", {7'd0, irq}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
